// File: rtl/weight_buffer_sched.sv
// Weight buffer sequencer: streams 512-bit beats into bank-group writes
// and issues one buffer read per fully written 9-row kernel set.
module weight_buffer_sched #(
  parameter int X_PE     = 16,
  parameter int X_MESH   = 16,
  parameter int ADDR_LEN = 16,
  parameter int DATA_LEN = 64,
  parameter int CNT_W    = 16,
  parameter int BUFFER_NUM = 8 * X_PE * X_MESH / DATA_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic [ADDR_LEN-1:0]   cfg_base,
  input  logic [CNT_W-1:0]      cfg_nsets,
  output logic                  busy,
  output logic                  done,
  input  logic [511:0]          s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [511:0]          data_wr,
  output logic [ADDR_LEN-1:0]   wr_addr,
  output logic [BUFFER_NUM-1:0] wr_en,
  output logic                  rd_conf,
  output logic [ADDR_LEN-1:0]   st_rd_addr,
  input  logic                  buf_idle,
  input  logic                  buf_ker_en,
  output logic                  ker_valid,
  input  logic                  ker_ack,
  output logic [CNT_W-1:0]      set_idx
);

  localparam int GRP   = BUFFER_NUM / 8;
  localparam int GW    = (GRP > 1) ? $clog2(GRP) : 1;
  localparam int ROW_W = CNT_W + 4;

  localparam logic [BUFFER_NUM-1:0] GRP_MASK =
    BUFFER_NUM'(8'hFF);

  typedef enum logic {
    J_IDLE,
    J_RUN
  } job_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ISSUE,
    R_WAIT,
    R_HOLD
  } rd_t;

  job_t                job_q, job_d;
  rd_t                 rd_q, rd_d;
  logic [ADDR_LEN-1:0] base_q, base_d;
  logic [CNT_W-1:0]    nsets_q, nsets_d;
  logic                done_q, done_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [GW-1:0]       grp_q, grp_d;
  logic [3:0]          kr_q, kr_d;
  logic [CNT_W-1:0]    wsets_q, wsets_d;
  logic [CNT_W-1:0]    rsets_q, rsets_d;
  logic [ADDR_LEN-1:0] st_rd_addr_q, st_rd_addr_d;
  logic [CNT_W-1:0]    set_idx_q, set_idx_d;

  logic                run;
  logic                fire;
  logic [ADDR_LEN-1:0] rs_a;
  logic [ADDR_LEN-1:0] rs9;
  logic [CNT_W-1:0]    rsets_inc;

  assign run  = (job_q == J_RUN);
  assign busy = run;
  assign done = done_q;

  // rst_n gating stops an accept or read pulse in the reset cycle itself
  assign s_ready = rst_n & run & (wsets_q != nsets_q);
  assign fire    = s_valid & s_ready;

  assign data_wr = s_data;
  assign wr_addr = base_q + row_q[ADDR_LEN-1:0];
  assign wr_en   = fire ? (GRP_MASK << {grp_q, 3'b000}) : '0;

  assign rd_conf    = rst_n & (rd_q == R_ISSUE);
  assign st_rd_addr = st_rd_addr_q;
  assign ker_valid  = (rd_q == R_HOLD);
  assign set_idx    = set_idx_q;

  assign rs_a      = ADDR_LEN'(rsets_q);
  assign rs9       = (rs_a << 3) + rs_a;
  assign rsets_inc = rsets_q + CNT_W'(1);

  always_comb begin
    job_d        = job_q;
    rd_d         = rd_q;
    base_d       = base_q;
    nsets_d      = nsets_q;
    done_d       = 1'b0;
    row_d        = row_q;
    grp_d        = grp_q;
    kr_d         = kr_q;
    wsets_d      = wsets_q;
    rsets_d      = rsets_q;
    st_rd_addr_d = st_rd_addr_q;
    set_idx_d    = set_idx_q;

    unique case (job_q)
      J_IDLE: begin
        if (cfg_start) begin
          if (cfg_nsets != '0) begin
            job_d   = J_RUN;
            base_d  = cfg_base;
            nsets_d = cfg_nsets;
            row_d   = '0;
            grp_d   = '0;
            kr_d    = '0;
            wsets_d = '0;
            rsets_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      J_RUN: begin
        if (fire) begin
          if (grp_q == GW'(GRP - 1)) begin
            grp_d = '0;
            row_d = row_q + ROW_W'(1);
            if (kr_q == 4'd8) begin
              kr_d    = '0;
              wsets_d = wsets_q + CNT_W'(1);
            end else begin
              kr_d = kr_q + 4'd1;
            end
          end else begin
            grp_d = grp_q + GW'(1);
          end
        end
      end
      default: job_d = J_IDLE;
    endcase

    // wsets is registered, so a set finished this cycle is read next cycle
    unique case (rd_q)
      R_IDLE: begin
        if (run && (rsets_q < nsets_q) &&
            (wsets_q > rsets_q) && buf_idle) begin
          rd_d         = R_ISSUE;
          st_rd_addr_d = base_q + rs9;
        end
      end
      R_ISSUE: rd_d = R_WAIT;
      R_WAIT: begin
        if (buf_ker_en) begin
          rd_d      = R_HOLD;
          set_idx_d = rsets_q;
        end
      end
      R_HOLD: begin
        if (ker_ack) begin
          rd_d    = R_IDLE;
          rsets_d = rsets_inc;
          if (rsets_inc == nsets_q) begin
            job_d  = J_IDLE;
            done_d = 1'b1;
          end
        end
      end
      default: rd_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      job_q        <= J_IDLE;
      rd_q         <= R_IDLE;
      base_q       <= '0;
      nsets_q      <= '0;
      done_q       <= 1'b0;
      row_q        <= '0;
      grp_q        <= '0;
      kr_q         <= '0;
      wsets_q      <= '0;
      rsets_q      <= '0;
      st_rd_addr_q <= '0;
      set_idx_q    <= '0;
    end else begin
      job_q        <= job_d;
      rd_q         <= rd_d;
      base_q       <= base_d;
      nsets_q      <= nsets_d;
      done_q       <= done_d;
      row_q        <= row_d;
      grp_q        <= grp_d;
      kr_q         <= kr_d;
      wsets_q      <= wsets_d;
      rsets_q      <= rsets_d;
      st_rd_addr_q <= st_rd_addr_d;
      set_idx_q    <= set_idx_d;
    end
  end

endmodule

// File: tb/tb_weight_buffer_sched.sv
// Bench for weight_buffer_sched: job table plus reset, empty-job
// and mid-write reset sequences against buffer and PE models.
module tb_weight_buffer_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_start;
  logic [15:0]  cfg_base;
  logic [15:0]  cfg_nsets;
  logic         busy, done;
  logic [511:0] s_data;
  logic         s_valid, s_ready;
  logic [511:0] data_wr;
  logic [15:0]  wr_addr;
  logic [31:0]  wr_en;
  logic         rd_conf;
  logic [15:0]  st_rd_addr;
  logic         buf_idle, buf_ker_en;
  logic         ker_valid, ker_ack;
  logic [15:0]  set_idx;

  always #5 clk = ~clk;

  weight_buffer_sched dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_base(cfg_base),
    .cfg_nsets(cfg_nsets), .busy(busy), .done(done),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .data_wr(data_wr), .wr_addr(wr_addr), .wr_en(wr_en),
    .rd_conf(rd_conf), .st_rd_addr(st_rd_addr),
    .buf_idle(buf_idle), .buf_ker_en(buf_ker_en),
    .ker_valid(ker_valid), .ker_ack(ker_ack),
    .set_idx(set_idx)
  );

  typedef struct {
    logic [15:0] base;
    logic [15:0] nsets;
    int          dly;
    bit          rnd;
    bit          poke;
    bit          ov;
    int          beats;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [15:0] a2;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  bit          mon_en = 1'b0;
  int          job_id = 0;
  int          job_start = 0;
  logic [15:0] job_base = '0;
  int          ack_dly = 0;

  int          acc_total = 0;
  int          done_cnt = 0;
  int          rdc_total = 0;
  int          rd_n = 0;
  int          kv_n = 0;
  int          ov_n = 0;
  int          last_id = 0;
  int          m_idx;
  logic        kv_prev = 1'b0;
  logic [15:0] rd_addr [8];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // buffer model: busy from rd_conf until ker_en 11 cycles later
  initial begin
    buf_idle   = 1'b1;
    buf_ker_en = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_conf === 1'b1) begin
        buf_idle = 1'b0;
        repeat (10) @(negedge clk);
        buf_ker_en = 1'b1;
        @(negedge clk);
        buf_ker_en = 1'b0;
        buf_idle   = 1'b1;
      end
    end
  end

  initial begin
    ker_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ker_valid === 1'b1) begin
        repeat (ack_dly) @(negedge clk);
        ker_ack = 1'b1;
        @(negedge clk);
        ker_ack = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (job_id != last_id) begin
          last_id = job_id;
          rd_n = 0;
          kv_n = 0;
          ov_n = 0;
        end
        if (rd_conf) begin
          chk("rd_conf_hold", 64'(ker_valid), 0);
          chk("rd_after_write",
              64'((acc_total - job_start) >= 36 * (rd_n + 1)), 1);
          if (rd_n < 8) rd_addr[rd_n] = st_rd_addr;
          rd_n++;
          rdc_total++;
        end
        if (s_valid && s_ready) begin
          m_idx = acc_total - job_start;
          chk("wr_en", 64'(wr_en),
              64'hFF << (8 * (m_idx % 4)));
          chk("wr_addr", 64'(wr_addr),
              64'(16'(job_base + 16'(m_idx / 4))));
          chk("data_wr", 64'(data_wr == s_data), 1);
          if (ker_valid) ov_n++;
          acc_total++;
        end else begin
          chk("wr_en_idle", 64'(wr_en), 0);
        end
        if (ker_valid && !kv_prev) begin
          chk("set_idx", 64'(set_idx), 64'(kv_n));
          kv_n++;
        end
        kv_prev = ker_valid;
        if (done) done_cnt++;
      end
    end
  end

  task automatic run_job(input vec_t v);
    int  d0, r0;
    bit  got;
    job_id++;
    job_base  = v.base;
    job_start = acc_total;
    ack_dly   = v.dly;
    d0 = done_cnt;
    r0 = rdc_total;
    @(posedge clk); #1;
    cfg_base  = v.base;
    cfg_nsets = v.nsets;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    chk("busy", 64'(busy), 1);
    got = 1'b0;
    for (int cyc = 0; cyc < 4000 && !got; cyc++) begin
      s_valid = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = {16{$urandom}};
      if (v.poke && cyc == 10) begin
        cfg_start = 1'b1;
        cfg_base  = 16'h0000;
        cfg_nsets = 16'd5;
      end else begin
        cfg_start = 1'b0;
      end
      @(posedge clk); #1;
      if (done_cnt != d0) got = 1'b1;
    end
    s_valid   = 1'b0;
    cfg_start = 1'b0;
    chk("timeout", 64'(got), 1);
    chk("done_once", 64'(done_cnt - d0), 1);
    chk("done_pulse", 64'(done), 0);
    chk("busy_end", 64'(busy), 0);
    chk("beats", 64'(acc_total - job_start), 64'(v.beats));
    chk("rd_conf_n", 64'(rdc_total - r0), 64'(v.nsets));
    chk("ker_sets", 64'(kv_n), 64'(v.nsets));
    chk("st_rd_addr0", 64'(rd_addr[0]), 64'(v.a0));
    if (v.nsets > 1)
      chk("st_rd_addr1", 64'(rd_addr[1]), 64'(v.a1));
    if (v.nsets > 2)
      chk("st_rd_addr2", 64'(rd_addr[2]), 64'(v.a2));
    if (v.ov)
      chk("overlap", 64'(ov_n > 0), 1);
  endtask

  initial begin
    vec_t vt [5];
    vec_t vr;
    int   d0, r0;
    bit   hit;

    vt[0] = '{16'h0000, 16'd1, 0, 1'b0, 1'b0, 1'b0, 36,
              16'h0000, 16'h0000, 16'h0000};
    vt[1] = '{16'd100, 16'd3, 20, 1'b0, 1'b0, 1'b1, 108,
              16'd100, 16'd109, 16'd118};
    vt[2] = '{16'd50, 16'd2, 3, 1'b1, 1'b0, 1'b0, 72,
              16'd50, 16'd59, 16'h0000};
    vt[3] = '{16'hFFFC, 16'd1, 2, 1'b0, 1'b1, 1'b0, 36,
              16'hFFFC, 16'h0000, 16'h0000};
    vt[4] = '{16'hFFF5, 16'd2, 1, 1'b1, 1'b0, 1'b0, 72,
              16'hFFF5, 16'hFFFE, 16'h0000};
    vr    = '{16'h0040, 16'd1, 1, 1'b0, 1'b0, 1'b0, 36,
              16'h0040, 16'h0000, 16'h0000};

    rst_n     = 1'b0;
    cfg_start = 1'b0;
    cfg_base  = '0;
    cfg_nsets = '0;
    s_valid   = 1'b0;
    s_data    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_s_ready", 64'(s_ready), 0);
    chk("rst_rd_conf", 64'(rd_conf), 0);
    chk("rst_ker_valid", 64'(ker_valid), 0);
    chk("rst_wr_en", 64'(wr_en), 0);
    chk("rst_wr_addr", 64'(wr_addr), 0);
    chk("rst_st_rd_addr", 64'(st_rd_addr), 0);
    chk("rst_set_idx", 64'(set_idx), 0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 5; i++) run_job(vt[i]);

    d0 = done_cnt;
    r0 = rdc_total;
    @(posedge clk); #1;
    cfg_base  = 16'd5;
    cfg_nsets = 16'd0;
    cfg_start = 1'b1;
    s_valid   = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    chk("empty_done", 64'(done), 1);
    chk("empty_busy", 64'(busy), 0);
    chk("empty_s_ready", 64'(s_ready), 0);
    @(posedge clk); #1;
    chk("empty_done_low", 64'(done), 0);
    repeat (5) @(posedge clk);
    #1;
    s_valid = 1'b0;
    chk("empty_rd_conf", 64'(rdc_total - r0), 0);
    chk("empty_done_n", 64'(done_cnt - d0), 1);

    job_id++;
    job_base  = 16'h0000;
    job_start = acc_total;
    r0 = rdc_total;
    @(posedge clk); #1;
    cfg_base  = 16'h0000;
    cfg_nsets = 16'd1;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    hit = 1'b0;
    for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
      s_valid = 1'b1;
      s_data  = {16{$urandom}};
      @(posedge clk); #1;
      if (acc_total - job_start >= 22) hit = 1'b1;
    end
    chk("rst_reach_row5", 64'(hit), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_wr_en", 64'(wr_en), 0);
    chk("mid_rst_s_ready", 64'(s_ready), 0);
    @(posedge clk); #1;
    chk("mid_rst_busy", 64'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_s_ready", 64'(s_ready), 0);
    chk("post_rst_wr_en", 64'(wr_en), 0);
    chk("post_rst_beats", 64'(acc_total - job_start), 22);
    s_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_rd_conf", 64'(rdc_total - r0), 0);
    run_job(vr);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
